// File: rtl/instruction_decode.sv
// ----------------------------------------------------------------------------
// instruction_decode
//
// Decode stage for an RV32I pipeline. It sits between the fetch instruction
// register (IR) and the execute stage. It holds one decoded bundle behind a
// valid/ready handshake. It tracks whether the fetch IR holds an instruction
// that has not been decoded yet (irFresh).
//
// Build option:
//   DECODE_ILLEGAL_CHECK_EN  when defined, a loaded bundle carries
//                            `EXC_ILLEGAL_INSTR for encodings outside RV32I.
//                            When undefined, exception_Out is always 0.
//
// Ports:
//   clk                  clock, all state changes on the rising edge
//   rst                  synchronous active-high reset, highest priority
//   instr_In  [31:0]     fetch IR contents
//   pc_In     [31:0]     fetch PC, already one instruction past instr_In
//   irUpdate_In          fetch IR loads on the coming edge
//   instrIsConsumed_Out  the fetch IR may be overwritten this cycle
//   flush_In             backend redirect; discards all held work
//   valid_Out            decoded bundle valid
//   ready_In             execute accepts the bundle this cycle
//   instrPc_Out [31:0]   address of the decoded instruction (pc_In - 4)
//   opcode_Out [6:0], funct3_Out [2:0], funct7b5_Out   raw fields
//   rd_Out, rs1_Out, rs2_Out [4:0]                    register indices
//   imm_Out   [31:0]     sign-extended immediate, 0 when the format has none
//   exception_Out        exception code for the bundle
// ----------------------------------------------------------------------------

`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXC_ILLEGAL_INSTR
`define EXC_ILLEGAL_INSTR 2
`endif

module instruction_decode (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               instr_In,
    input  logic [31:0]               pc_In,
    input  logic                      irUpdate_In,
    output logic                      instrIsConsumed_Out,
    input  logic                      flush_In,
    output logic                      valid_Out,
    input  logic                      ready_In,
    output logic [31:0]               instrPc_Out,
    output logic [6:0]                opcode_Out,
    output logic [2:0]                funct3_Out,
    output logic                      funct7b5_Out,
    output logic [4:0]                rd_Out,
    output logic [4:0]                rs1_Out,
    output logic [4:0]                rs2_Out,
    output logic [31:0]               imm_Out,
    output logic [`EXCEPTION_LEN-1:0] exception_Out
);

    // RV32I major opcodes; every one of them has instr[1:0] == 2'b11.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bundle_t;

    logic    ir_fresh_q, ir_fresh_d;
    logic    valid_q, valid_d;
    bundle_t bundle_q, bundle_d;
    logic    load;
    logic [31:0] imm;

    // The IR holds an undecoded instruction and the output slot is free or is
    // being drained this cycle. A flush discards the IR, so nothing loads.
    assign load = ir_fresh_q && (!valid_q || ready_In) && !flush_In;

    // Fetch may overwrite the IR when the IR holds no undecoded instruction,
    // or when that instruction is being captured on this edge.
    assign instrIsConsumed_Out = !ir_fresh_q || load;

    // Immediate generation. Formats with no immediate, and unknown opcodes,
    // produce 0.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        imm = '0;
        case (instr_In[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr_In[31]}}, instr_In[31:20]};
            OPC_STORE:
                imm = {{20{instr_In[31]}}, instr_In[31:25], instr_In[11:7]};
            OPC_BRANCH:
                imm = {{19{instr_In[31]}}, instr_In[31], instr_In[7],
                       instr_In[30:25], instr_In[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr_In[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr_In[31]}}, instr_In[31], instr_In[19:12],
                       instr_In[20], instr_In[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    // Next-state logic. A flush beats both load and irUpdate_In. A load and
    // a new IR write can happen on the same edge, and then irFresh stays set.
    always_comb begin
        ir_fresh_d = ir_fresh_q;
        valid_d    = valid_q;
        bundle_d   = bundle_q;

        if (flush_In) begin
            ir_fresh_d = 1'b0;
            valid_d    = 1'b0;
        end else begin
            if (load) begin
                valid_d           = 1'b1;
                bundle_d.pc       = pc_In - 32'd4;
                bundle_d.opcode   = instr_In[6:0];
                bundle_d.funct3   = instr_In[14:12];
                bundle_d.funct7b5 = instr_In[30];
                bundle_d.rd       = instr_In[11:7];
                bundle_d.rs1      = instr_In[19:15];
                bundle_d.rs2      = instr_In[24:20];
                bundle_d.imm      = imm;
            end else if (valid_q && ready_In) begin
                valid_d = 1'b0;
            end

            if (irUpdate_In) begin
                ir_fresh_d = 1'b1;
            end else if (load) begin
                ir_fresh_d = 1'b0;
            end
        end
    end

    // NOTE: the bundle registers are reset as well as the control flags, so
    // downstream logic sees all-zero fields after reset and never X values.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            ir_fresh_q <= 1'b0;
            valid_q    <= 1'b0;
            bundle_q   <= '0;
        end else begin
            ir_fresh_q <= ir_fresh_d;
            valid_q    <= valid_d;
            bundle_q   <= bundle_d;
        end
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic                      illegal;
    logic [`EXCEPTION_LEN-1:0] exception_q, exception_d;

    // Legality of the RV32I encoding. The default arm covers both unknown
    // opcodes and instr[1:0] != 2'b11, because every RV32I opcode ends in 11.
    // SYSTEM accepts every funct3 except the reserved 100.
    always_comb begin
        illegal = 1'b0;
        case (instr_In[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL:
                illegal = 1'b0;
            OPC_JALR:
                illegal = (instr_In[14:12] != 3'b000);
            OPC_BRANCH:
                illegal = (instr_In[14:12] == 3'b010) || (instr_In[14:12] == 3'b011);
            OPC_LOAD:
                illegal = (instr_In[14:12] == 3'b011) || (instr_In[14:12] == 3'b110) ||
                          (instr_In[14:12] == 3'b111);
            OPC_STORE:
                illegal = (instr_In[14:12] > 3'b010);
            OPC_OP_IMM: begin
                // Only the shifts carry a funct7 field. SRAI is the only
                // shift that may set bit 30.
                if (instr_In[14:12] == 3'b001) begin
                    illegal = (instr_In[31:25] != 7'h00);
                end else if (instr_In[14:12] == 3'b101) begin
                    illegal = (instr_In[31:25] != 7'h00) && (instr_In[31:25] != 7'h20);
                end
            end
            OPC_OP: begin
                // funct7 0x20 exists only for SUB and SRA.
                illegal = !((instr_In[31:25] == 7'h00) ||
                            ((instr_In[31:25] == 7'h20) &&
                             ((instr_In[14:12] == 3'b000) || (instr_In[14:12] == 3'b101))));
            end
            OPC_MISC_MEM:
                illegal = (instr_In[14:12] != 3'b000);
            OPC_SYSTEM:
                illegal = (instr_In[14:12] == 3'b100);
            default:
                illegal = 1'b1;
        endcase
    end

    always_comb begin
        exception_d = exception_q;
        if (!flush_In && load) begin
            exception_d = illegal ? `EXCEPTION_LEN'(`EXC_ILLEGAL_INSTR) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exception_q <= '0;
        end else begin
            exception_q <= exception_d;
        end
    end

    assign exception_Out = exception_q;
`else
    assign exception_Out = '0;
`endif

    assign valid_Out    = valid_q;
    assign instrPc_Out  = bundle_q.pc;
    assign opcode_Out   = bundle_q.opcode;
    assign funct3_Out   = bundle_q.funct3;
    assign funct7b5_Out = bundle_q.funct7b5;
    assign rd_Out       = bundle_q.rd;
    assign rs1_Out      = bundle_q.rs1;
    assign rs2_Out      = bundle_q.rs2;
    assign imm_Out      = bundle_q.imm;

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have clk  input  1  clock; all state changes on posedge clk.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have instr_In  input  32  fetch-stage IR contents.
REQ-004 SHALL have pc_In  input  32  fetch PC; points to the instruction after instr_In.
REQ-005 SHALL have irUpdate_In  input  1  fetch IR loads on the coming edge; driven by fetch canWriteBack.
REQ-006 SHALL have instrIsConsumed_Out  output  1  IR may be replaced; drives fetch instrIsConsumed.
REQ-007 SHALL have flush_In  input  1  backend redirect; discards all held work.
REQ-008 SHALL have valid_Out  output  1  decoded bundle valid.
REQ-009 SHALL have ready_In  input  1  execute accepts the bundle this cycle.
REQ-010 SHALL have instrPc_Out  output  32  address of the decoded instruction.
REQ-011 SHALL have opcode_Out, funct3_Out, funct7b5_Out  output  7/3/1  raw instruction fields.
REQ-012 SHALL have rd_Out, rs1_Out, rs2_Out  output  5 each  register indices.
REQ-013 SHALL have imm_Out  output  32  sign-extended immediate.
REQ-014 SHALL have exception_Out  output  `EXCEPTION_LEN  exception code for the bundle.

Function
REQ-015 SHALL set internal flag irFresh on any edge where irUpdate_In=1 and flush_In=0.
REQ-016 SHALL define load = irFresh && (!valid_Out || ready_In) && !flush_In.
REQ-017 SHALL drive instrIsConsumed_Out = !irFresh || load, combinationally.
REQ-018 SHALL, on load, register all decoded fields, set valid_Out=1, and clear irFresh unless irUpdate_In=1 in the same cycle.
REQ-019 SHALL, when valid_Out && ready_In && !load, clear valid_Out next edge.
REQ-020 SHALL hold all outputs stable while valid_Out=1 and ready_In=0.
REQ-021 SHALL compute instrPc_Out = pc_In - 4, mod 2^32; pc_In=0 yields 0xFFFFFFFC.
REQ-022 SHALL form imm_Out by type: I (OP-IMM, LOAD, JALR), S, B, U, J; bit 31 sign-extends, B/J have bit 0 = 0, U has low 12 bits zero; all other opcodes yield 0.
REQ-023 SHALL, on flush_In=1, clear valid_Out and irFresh next edge; flush takes priority over load and irUpdate_In.
REQ-024 SHALL accept back-to-back instructions: one per cycle sustained while ready_In=1.
REQ-025 SHALL have decode latency of 1 cycle from the first cycle irFresh=1 to valid_Out=1 when the output slot is free.

Reset
REQ-026 SHALL, on rst, clear valid_Out and irFresh, zero all field outputs and imm_Out, and set exception_Out=0.
REQ-027 SHALL give rst priority over flush_In, load and irUpdate_In.
REQ-028 SHALL drive instrIsConsumed_Out=1 in the first cycle after reset.

Configuration
REQ-029 SHALL, with DECODE_ILLEGAL_CHECK_EN defined, set exception_Out=`EXC_ILLEGAL_INSTR on load for an opcode outside RV32I, instr[1:0]!=2'b11, or an invalid funct3/funct7 combination (e.g. OP with funct7 not 0x00/0x20); otherwise exception_Out=0.
REQ-030 SHALL, without DECODE_ILLEGAL_CHECK_EN, hold exception_Out=0 always; unknown encodings pass through undecoded, with imm_Out=0.

Verification
REQ-031 SHALL verify: instr 0x00500093, pc_In 0x104, irUpdate pulse, ready_In=1 -> valid_Out=1 next cycle, rd=1, rs1=0, imm=0x00000005, instrPc=0x100.
REQ-032 SHALL verify: instr 0xFFF00093 -> imm_Out=0xFFFFFFFF; instr 0xFE000EE3 (beq x0,x0,-4) -> imm_Out=0xFFFFFFFC.
REQ-033 SHALL verify: ready_In=0 for 3 cycles with bundle valid and new IR pending -> outputs unchanged, instrIsConsumed_Out=0; ready_In=1 -> next bundle loads the same edge.
REQ-034 SHALL verify: flush_In=1 with valid_Out=1 and irFresh=1 -> valid_Out=0 next edge, instrIsConsumed_Out=1.
REQ-035 SHALL verify: instr 0x00000000 with DECODE_ILLEGAL_CHECK_EN -> exception_Out=`EXC_ILLEGAL_INSTR; without the macro -> exception_Out=0.
REQ-036 SHALL verify: rst asserted mid-stall with valid_Out=1 -> all outputs zero next edge, valid_Out=0.
